// File: rtl/dpy_bcd_convert.sv
// dpy_bcd_convert: sequential binary-to-BCD converter (shift-and-add-3),
// one input bit per clock. Feeds the seven-segment scanner so numbers show
// in decimal. The result register only updates when a conversion finishes.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   bin holds a value to convert
//   in_ready   ready to accept (IDLE only)
//   bin        unsigned binary input, sampled on accept
//   bcd_out    packed BCD result, digit 0 in [3:0], held between conversions
//   overflow   last result saturated to all nines
//   out_valid  one-cycle pulse when a new result first appears
//   busy       conversion in progress (SHIFT or DONE)
//
// state   | meaning
// S_IDLE  | waiting for in_valid, in_ready high
// S_SHIFT | one add-3/shift iteration per cycle, BIN_WIDTH cycles
// S_DONE  | result visible, out_valid pulse, back to IDLE next cycle
module dpy_bcd_convert #(
  parameter int BIN_WIDTH = 27,
  parameter int DIGITS    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_WIDTH-1:0]   bin,
  output logic [4*DIGITS-1:0]    bcd_out,
  output logic                   overflow,
  output logic                   out_valid,
  output logic                   busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] max_dec(input int d);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  // Largest value representable in DIGITS decimal digits, kept at 64 bits so
  // the compare never truncates for any legal BIN_WIDTH.
  localparam logic [63:0]   MAX_DEC   = max_dec(DIGITS);
  localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]        acc_q, acc_d, acc_adj;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 ovf_q, ovf_d;
  logic [63:0]          bin_ext;

  assign bin_ext = 64'(bin);

  // Per-digit add-3 correction, no carry between digits.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sr_d       = bin;
          acc_d      = '0;
          cnt_d      = CW'(BIN_WIDTH);
          ovf_pend_d = (bin_ext > MAX_DEC);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = {acc_adj[BW-2:0], sr_q[BIN_WIDTH-1]};
        sr_d  = {sr_q[BIN_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Load the result from the final shifted value so it is visible in DONE.
          bcd_d   = ovf_pend_q ? ALL_NINES : {acc_adj[BW-2:0], sr_q[BIN_WIDTH-1]};
          ovf_d   = ovf_pend_q;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign bcd_out   = bcd_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_dpy_bcd_convert.sv
module tb_dpy_bcd_convert;

  localparam int BIN_WIDTH = 27;
  localparam int DIGITS    = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIN_WIDTH-1:0] bin;
  logic [4*DIGITS-1:0]  bcd_out;
  logic                 overflow;
  logic                 out_valid;
  logic                 busy;

  dpy_bcd_convert #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin(bin), .bcd_out(bcd_out), .overflow(overflow),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  logic rst_d = 1'b1;
  logic [31:0] last_bcd = '0;
  logic        last_ovf = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: decimal digits by division, saturate above 8 digits.
  function automatic exp_t model(input logic [BIN_WIDTH-1:0] v);
    exp_t e;
    int   x;
    x = int'(v);
    e.bcd = '0;
    e.ovf = 1'b0;
    e.cyc = 0;
    if (x > 99999999) begin
      e.bcd = 32'h99999999;
      e.ovf = 1'b1;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        e.bcd[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return e;
  endfunction

  // Monitor: pops one expectation per out_valid; otherwise the result must hold.
  always @(negedge clk) begin
    if (started) begin
      if (rst_d) begin
        last_bcd = '0;
        last_ovf = 1'b0;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
      end else if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("bcd_out", 64'(bcd_out), 64'(e.bcd));
          chk("overflow", 64'(overflow), 64'(e.ovf));
          chk("out_valid_cycle", 64'(cyc), 64'(e.cyc));
          last_bcd = e.bcd;
          last_ovf = e.ovf;
        end
      end else begin
        chk("bcd_hold", 64'(bcd_out), 64'(last_bcd));
        chk("ovf_hold", 64'(overflow), 64'(last_ovf));
      end
    end
  end

  task automatic send(input logic [BIN_WIDTH-1:0] v, input bit hold, output int acc);
    int   t;
    exp_t e;
    t = 0;
    acc = -1;
    @(negedge clk);
    bin = v;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      e = model(v);
      e.cyc = acc + BIN_WIDTH;
      q.push_back(e);
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_bcd"}, 64'(bcd_out), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int a, a2, t;
    logic [BIN_WIDTH-1:0] v;
    rst = 1'b1;
    in_valid = 1'b0;
    bin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    started = 1;

    // Basic conversion with exact ready timing.
    send(27'd12345678, 0, a);
    t = 0;
    while (cyc != a + BIN_WIDTH && t < 100) begin @(negedge clk); t++; end
    chk("in_ready_in_done", 64'(in_ready), 64'd0);
    chk("busy_in_done", 64'(busy), 64'd1);
    @(negedge clk);
    chk("in_ready_after_done", 64'(in_ready), 64'd1);

    // Boundaries.
    send(27'd0, 0, a);
    send(27'd99999999, 0, a);
    send(27'd100000000, 0, a);
    send(27'd134217727, 0, a);
    send(27'd42, 0, a);

    // in_valid held continuously across a conversion.
    send(27'd1111, 1, a);
    bin = 27'd2222;
    send(27'd2222, 0, a2);
    chk("back_to_back_spacing", 64'(a2 - a), 64'(BIN_WIDTH + 2));

    // Reset mid-conversion discards the result.
    send(27'd55555555, 0, a);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_idle("abort");
    repeat (40) @(negedge clk);
    send(27'd7, 0, a);

    // Random values with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      v = BIN_WIDTH'($urandom_range(0, 134217727));
      if ($urandom_range(0, 3) == 0) v = BIN_WIDTH'($urandom_range(0, 9999));
      send(v, 0, a);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    t = 0;
    while (q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dpy_bcd_convert.md
Name: dpy_bcd_convert

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double-dabble), one bit per cycle.
- Sits directly upstream of the 8-digit seven-segment scanner. Its packed BCD output drives the scanner's 32-bit number input, so values appear as decimal rather than hex.
- The output is held in a register and changes only when a conversion completes, so the display never shows intermediate values.

Parameters:
- BIN_WIDTH, 27, width of the binary input. Legal range 4..32.
- DIGITS, 8, number of BCD digits produced. The output is 4*DIGITS bits; 8 digits matches the scanner.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  bin holds a value to convert.
- in_ready  output  1  block can accept a value; high only in IDLE.
- bin  input  BIN_WIDTH  unsigned binary value. Sampled only on an accept.
- bcd_out  output  4*DIGITS  packed BCD. Digit 0 (least significant) is in bits [3:0]. Registered and held between conversions.
- overflow  output  1  last result saturated. Updated together with bcd_out.
- out_valid  output  1  one-cycle pulse marking the cycle bcd_out/overflow first show a new result.
- busy  output  1  high in SHIFT and DONE.

Behaviour:
- Reset (rst high at a rising edge):
  - state goes to IDLE.
  - bcd_out = 0, overflow = 0, out_valid = 0, busy = 0, in_ready = 1.
  - Internal shift and BCD accumulators are cleared.
  - Reset has priority over everything, including mid-conversion; the aborted result is discarded and never output.
- Accept:
  - Occurs on a rising edge where in_valid and in_ready are both high.
  - bin is latched into a BIN_WIDTH shift register.
  - The BCD accumulator (4*DIGITS bits) is cleared.
  - An iteration counter is loaded with BIN_WIDTH.
  - ovf_pending is set if bin > 10^DIGITS - 1. The comparison is done on the latched value at accept time, using a constant of sufficient width.
  - State goes to SHIFT.
- State IDLE:
  - in_ready = 1, busy = 0.
  - in_valid without an accept has no effect.
- State SHIFT: one iteration per cycle, for exactly BIN_WIDTH cycles. Each cycle:
  - Every BCD digit >= 5 has 3 added to it (4-bit add, no carry between digits).
  - The {BCD accumulator, shift register} is then shifted left by 1, so the shift register MSB enters BCD bit 0.
  - The counter is decremented.
  - After the iteration with counter == 1, state goes to DONE.
  - in_ready = 0, busy = 1. in_valid is ignored; no queueing.
- State DONE (exactly one cycle):
  - bcd_out and overflow are registered on the edge entering DONE, so they are visible in the DONE cycle.
  - If ovf_pending: bcd_out = all digits 9 (0x99999999 for DIGITS = 8) and overflow = 1.
  - Otherwise: bcd_out = accumulator and overflow = 0.
  - out_valid = 1, in_ready = 0, busy = 1.
  - Next state is IDLE.
- Latency and throughput:
  - Accept at edge k.
  - SHIFT occupies cycles k+1 .. k+BIN_WIDTH.
  - out_valid is high in cycle k+BIN_WIDTH+1.
  - in_ready is high again from cycle k+BIN_WIDTH+2.
  - Minimum spacing between accepts is BIN_WIDTH+2 cycles (29 for defaults).
- Boundaries:
  - bin = 0 gives an all-zero result.
  - bin = 10^DIGITS - 1 converts exactly, with overflow = 0.
  - If 2^BIN_WIDTH - 1 < 10^DIGITS, overflow can never assert. This is legal.
  - in_valid asserted in the same cycle as the DONE pulse is not accepted. It is accepted on the following edge if still held.
- Arithmetic: all digit adds are 4-bit unsigned. Correct double-dabble never produces a digit > 9 after the final shift.

Test Plan:
- Reset, then check idle state → bcd_out = 0x00000000, overflow = 0, in_ready = 1, out_valid = 0.
- Accept bin = 12345678 at edge k → out_valid high only in cycle k+28, bcd_out = 0x12345678, overflow = 0, in_ready high again at k+29.
- Accept bin = 0, then bin = 99999999 (one accept each) → 0x00000000 with overflow = 0, then 0x99999999 with overflow = 0.
- Accept bin = 100000000, then bin = 134217727 (one accept each) → bcd_out = 0x99999999 with overflow = 1 for both. Then accept 42 → 0x00000042 with overflow cleared.
- Accept 1111, then hold in_valid = 1 with bin = 2222 continuously:
  - bin is ignored during SHIFT/DONE; the second accept occurs exactly 29 cycles after the first.
  - Results are 0x00001111 then 0x00002222.
  - bcd_out stays 0x00001111 between the two out_valid pulses.
- Accept 55555555, then assert rst for one cycle 10 cycles later → all outputs at reset values, no out_valid pulse. A subsequent accept of 7 gives 0x00000007.
